serial_adder_ctrl: RTL and testbench
====================================

# serial_adder_ctrl

Bit-serial adder controller. It accepts two WIDTH-bit operands and a carry-in over a valid/ready handshake, then drives one gate-level 1-bit full-adder cell LSB-first for WIDTH cycles. It returns the WIDTH-bit sum and carry-out over a second valid/ready handshake. It sits between the operand source and the gate-level adder datapath, and trades area (one full-adder cell) for latency.

## Interface

Parameters:

- WIDTH, 8, operand and sum width in bits. Legal values are WIDTH ≥ 2.

Ports:

- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand source offers a, b, cin.
- in_ready  output  1  controller can accept operands.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in.
- out_valid  output  1  sum and cout are valid.
- out_ready  input  1  consumer accepts the result.
- sum  output  WIDTH  (a + b + cin) mod 2^WIDTH.
- cout  output  1  bit WIDTH of a + b + cin.
- busy  output  1  high whenever state ≠ IDLE.

## Operation

- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready, load a and b into shift registers, carry reg ← cin, bit counter ← 0, go to RUN.
- RUN (one bit per cycle):
  - s = a_sr[0] ^ b_sr[0] ^ carry.
  - carry ← majority(a_sr[0], b_sr[0], carry).
  - a_sr and b_sr shift right by one.
  - sum_sr shifts right with s inserted at the MSB.
  - counter increments.
  - When counter == WIDTH-1, go to DONE after this bit.
- DONE:
  - out_valid = 1.
  - sum = sum_sr and cout = carry, both held stable until the handshake.
  - On out_ready, go to IDLE.
- in_ready = 0 in RUN and DONE. in_valid is ignored outside IDLE and operands are not queued.
- a, b and cin are sampled only on the accept edge. They may change freely afterwards.
- sum and cout are registered. Outside DONE they keep their last values; only out_valid qualifies them.
- Counter width is $clog2(WIDTH). The counter never wraps, because it exits at WIDTH-1.

## Timing

- Reset values:
  - state = IDLE.
  - in_ready = 0 while rst is high, 1 in the first cycle after release.
  - out_valid = 0, sum = 0, cout = 0, busy = 0.
  - Shift registers, carry and counter = 0.
- Latency: with accept on edge E0, bits 0..WIDTH-1 are processed on edges E1..E(WIDTH). out_valid rises after E(WIDTH), i.e. WIDTH cycles after acceptance.
- Throughput: with out_ready held high, one operation completes every WIDTH+2 cycles: WIDTH RUN cycles, 1 DONE cycle and 1 IDLE cycle.
- Backpressure: DONE holds indefinitely while out_ready = 0, with outputs unchanged.
- out_ready asserted outside DONE has no effect.
- Simultaneous in_valid and out_ready in DONE: the result is delivered, and the new operands are not accepted until the following IDLE cycle.
- Reset mid-RUN or mid-DONE: the operation is aborted immediately and asynchronously. No out_valid is issued for it, and all outputs take their reset values.

## Structure

- Shared package add_pkg holds:
  - typedef enum logic [1:0] {IDLE, RUN, DONE} serial_add_state_t.
  - localparam DEFAULT_ADD_WIDTH = 8.
- Sub-module full_adder_bit: purely combinational.
  - Inputs a, b, cin; outputs s, cout.
  - Built from the team's gate primitives.
  - Instantiated once, on the LSBs of the shift registers.
- The controller contains only the FSM, the shift registers, the carry register and the counter. It contains no arithmetic operators on WIDTH-bit vectors.

## Test plan

All scenarios use WIDTH = 8.

- Basic add: a = 0x3C, b = 0x45, cin = 0 → sum = 0x81, cout = 0. out_valid rises exactly 8 cycles after the accept edge.
- Carry ripple: a = 0xFF, b = 0x01, cin = 0 → sum = 0x00, cout = 1.
- Max with carry-in: a = 0xFF, b = 0xFF, cin = 1 → sum = 0xFF, cout = 1.
- Backpressure and busy: hold out_ready = 0 for 5 cycles in DONE → sum and cout are stable and out_valid stays high. A second in_valid with a = 0x01, b = 0x01 during RUN/DONE is not accepted (in_ready = 0). It is accepted only in the IDLE cycle after delivery, and yields sum = 0x02.
- Reset mid-operation: assert rst at RUN bit 3 → busy = 0 and out_valid = 0 immediately. The next operation (a = 0x10, b = 0x20, cin = 0) returns sum = 0x30, cout = 0.
- Back-to-back: 4 operations with in_valid and out_ready held high → results complete every 10 cycles, and every sum/cout matches a + b + cin.

Source files
------------

// File: rtl/add_pkg.sv
// Shared types and defaults for the bit-serial adder controller.
package add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } serial_add_state_t;

  localparam int DEFAULT_ADD_WIDTH = 8;

endpackage

// File: rtl/full_adder_bit.sv
// One-bit full adder cell built from gate primitives; the only arithmetic in the serial adder.
module full_adder_bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic ab_and;
  logic ac_and;
  logic bc_and;

  xor g_sum (s, a, b, cin);

  and g_ab (ab_and, a, b);
  and g_ac (ac_and, a, cin);
  and g_bc (bc_and, b, cin);
  or  g_maj (cout, ab_and, ac_and, bc_and);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: accepts operands, feeds one full-adder cell LSB-first,
// and presents the registered sum/carry-out over a valid/ready handshake.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for operands; in_ready high
// RUN   | one bit per cycle through the full-adder cell, LSB first
// DONE  | result held on sum/cout with out_valid until out_ready
module serial_adder_ctrl
  import add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_ADD_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH);

  serial_add_state_t state;
  serial_add_state_t state_nxt;

  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] sum_sr;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;

  logic fa_s;
  logic fa_c;
  logic accept;
  logic last_bit;

  full_adder_bit u_fa (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .cin  (carry),
    .s    (fa_s),
    .cout (fa_c)
  );

  // in_ready is gated by rst so it reads low for the whole reset interval
  assign in_ready  = (state == IDLE) & ~rst;
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign accept    = in_valid & in_ready;
  assign last_bit  = (cnt == CNT_W'(WIDTH - 1));
  assign sum       = sum_q;
  assign cout      = cout_q;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept) state_nxt = RUN;
      RUN:     if (last_bit) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand/sum shift registers, carry and bit counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sr   <= '0;
      b_sr   <= '0;
      sum_sr <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
    end else if (state == IDLE) begin
      if (accept) begin
        a_sr  <= a;
        b_sr  <= b;
        carry <= cin;
        cnt   <= '0;
      end
    end else if (state == RUN) begin
      a_sr   <= {1'b0, a_sr[WIDTH-1:1]};
      b_sr   <= {1'b0, b_sr[WIDTH-1:1]};
      sum_sr <= {fa_s, sum_sr[WIDTH-1:1]};
      carry  <= fa_c;
      // hold at WIDTH-1 on the final bit so the counter never wraps
      if (!last_bit) cnt <= cnt + CNT_W'(1);
    end
  end

  // Result registers, captured on the final bit so they stay stable outside DONE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else if (state == RUN && last_bit) begin
      sum_q  <= {fa_s, sum_sr[WIDTH-1:1]};
      cout_q <= fa_c;
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed self-checking bench for serial_adder_ctrl at WIDTH = 8.
module tb_serial_adder_ctrl;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             busy;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;

  serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Steps until out_valid is seen (bounded); returns the number of edges taken.
  task automatic wait_valid(input string tag, output int n);
    n = 0;
    while (out_valid !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    check({tag, "_out_valid_seen"}, out_valid, 1);
  endtask

  // Full single operation: accept, latency, result, delivery.
  task automatic run_op(input string tag, input logic [7:0] av, input logic [7:0] bv,
                        input logic cv, input logic [7:0] exp_sum, input logic exp_cout);
    int n;
    a = av; b = bv; cin = cv; in_valid = 1'b1;
    check({tag, "_in_ready"}, in_ready, 1);
    step();
    in_valid = 1'b0;
    a = 8'hxx; b = 8'hxx; cin = 1'bx;
    check({tag, "_busy"}, busy, 1);
    wait_valid(tag, n);
    check({tag, "_latency"}, n, 8);
    check({tag, "_sum"}, sum, exp_sum);
    check({tag, "_cout"}, cout, exp_cout);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check({tag, "_idle_after"}, busy, 0);
    check({tag, "_sum_kept"}, sum, exp_sum);
  endtask

  logic [7:0] op_a [4];
  logic [7:0] op_b [4];
  logic       op_c [4];
  logic [7:0] ex_s [4];
  logic       ex_c [4];

  initial begin
    int n;
    int t_prev;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", in_ready, 1);

    run_op("basic", 8'h3C, 8'h45, 1'b0, 8'h81, 1'b0);
    run_op("ripple", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
    run_op("maxcin", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);

    // Backpressure with a competing offer during RUN/DONE
    a = 8'h55; b = 8'h0A; cin = 1'b1; in_valid = 1'b1;
    step();
    a = 8'h01; b = 8'h01; cin = 1'b0;
    check("bp_run_in_ready", in_ready, 0);
    wait_valid("bp", n);
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_hold_valid", out_valid, 1);
      check("bp_hold_sum", sum, 8'h60);
      check("bp_hold_cout", cout, 0);
      check("bp_hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("bp_deliver_idle", busy, 0);
    check("bp_second_ready", in_ready, 1);
    step();
    in_valid = 1'b0;
    check("bp_second_busy", busy, 1);
    wait_valid("bp2", n);
    check("bp2_sum", sum, 8'h02);
    check("bp2_cout", cout, 0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // Reset at RUN bit 3
    a = 8'h77; b = 8'h11; cin = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (3) step();
    check("mid_busy_before", busy, 1);
    rst = 1'b1;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_sum", sum, 0);
    step();
    rst = 1'b0;
    #1;
    check("mid_post_ready", in_ready, 1);
    run_op("after_rst", 8'h10, 8'h20, 1'b0, 8'h30, 1'b0);

    // Back-to-back with in_valid and out_ready held high
    op_a = '{8'h12, 8'h80, 8'hAA, 8'h7F};
    op_b = '{8'h34, 8'h80, 8'h55, 8'h01};
    op_c = '{1'b0, 1'b0, 1'b1, 1'b0};
    ex_s = '{8'h46, 8'h00, 8'h00, 8'h80};
    ex_c = '{1'b0, 1'b1, 1'b1, 1'b0};
    t_prev = 0;
    a = op_a[0]; b = op_b[0]; cin = op_c[0];
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("b2b_accept", busy, 1);
      if (i < 3) begin
        a = op_a[i+1]; b = op_b[i+1]; cin = op_c[i+1];
      end else begin
        in_valid = 1'b0;
      end
      wait_valid("b2b", n);
      check("b2b_sum", sum, ex_s[i]);
      check("b2b_cout", cout, ex_c[i]);
      if (i > 0) check("b2b_period", cyc - t_prev, 10);
      t_prev = cyc;
      step();
      check("b2b_delivered", out_valid, 0);
    end
    out_ready = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
